time_bin_sequencer: RTL and testbench

//  Controls the PMT time-bin acquisition. Times NUM_BINS consecutive bins of BIN_CYCLES

---
 rtl/time_bin_sequencer.sv | 140 ++++++++++++++
 tb/tb_time_bin_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_bin_sequencer.sv
// time_bin_sequencer
//   Times NUM_BINS consecutive acquisition bins of BIN_CYCLES clocks each. At
//   every bin close it captures the PMT count, saturated to COUNT_W bits, and
//   pulses count_clear so the count module restarts. After the final bin the
//   stored values are streamed out over a valid/ready handshake.
// Ports
//   clk, reset_n      system clock; synchronous active-low reset
//   start, abort      run control (abort has priority, start only honoured idle)
//   pmt_count         running count from the PMT count module
//   count_clear       1-cycle restart pulse to the count module
//   bin_data/index    stored count and its bin number, qualified by bin_valid
//   bin_ready         consumer accept
//   busy, done, led   run/drain status, end-of-drain pulse, bin-close toggle
module time_bin_sequencer #(
  parameter int BIN_CYCLES = 100000000,
  parameter int NUM_BINS   = 4,
  parameter int COUNT_W    = 8,
  parameter int IN_W       = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [IN_W-1:0]    pmt_count,
  output logic               count_clear,
  output logic [COUNT_W-1:0] bin_data,
  output logic [3:0]         bin_index,
  output logic               bin_valid,
  input  logic               bin_ready,
  output logic               busy,
  output logic               done,
  output logic               led
);

  localparam int TW = $clog2(BIN_CYCLES);
  localparam int IW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int EW = (IN_W > COUNT_W) ? IN_W : COUNT_W;

  localparam logic [TW-1:0] T_LAST  = TW'(BIN_CYCLES - 1);
  localparam logic [3:0]    B_LAST  = 4'(NUM_BINS - 1);
  localparam logic [EW-1:0] SAT_MAX = EW'({COUNT_W{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t             state;
  logic [TW-1:0]      timer;
  logic [3:0]         bin_idx;
  logic [3:0]         rd_idx;
  logic [COUNT_W-1:0] store [2**IW];

  logic [EW-1:0]      pmt_ext;
  logic [COUNT_W-1:0] pmt_sat;

  // Widen both sides to a common width so saturation works for any IN_W/COUNT_W.
  always_comb begin
    pmt_ext = EW'(pmt_count);
    pmt_sat = pmt_ext[COUNT_W-1:0];
    if (pmt_ext > SAT_MAX) pmt_sat = '1;
  end

  // Read port is a mux of registered state; it holds while rd_idx holds.
  assign bin_data  = store[rd_idx[IW-1:0]];
  assign bin_index = rd_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      bin_idx     <= '0;
      rd_idx      <= '0;
      count_clear <= 1'b0;
      bin_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      led         <= 1'b0;
      for (int unsigned i = 0; i < 2**IW; i++) store[i] <= '0;
    end else begin
      count_clear <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        // Only a live run/drain needs the count module restarted.
        if (state != IDLE) count_clear <= 1'b1;
        state     <= IDLE;
        timer     <= '0;
        bin_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state       <= RUN;
              timer       <= '0;
              bin_idx     <= '0;
              rd_idx      <= '0;
              count_clear <= 1'b1;
              busy        <= 1'b1;
              for (int unsigned i = 0; i < 2**IW; i++) store[i] <= '0;
            end
          end
          RUN: begin
            if (timer == T_LAST) begin
              store[bin_idx[IW-1:0]] <= pmt_sat;
              count_clear            <= 1'b1;
              led                    <= ~led;
              timer                  <= '0;
              if (bin_idx == B_LAST) begin
                state     <= DRAIN;
                rd_idx    <= '0;
                bin_valid <= 1'b1;
              end else begin
                bin_idx <= bin_idx + 4'd1;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          DRAIN: begin
            if (bin_ready) begin
              if (rd_idx == B_LAST) begin
                state     <= IDLE;
                rd_idx    <= '0;
                bin_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                rd_idx <= rd_idx + 4'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_bin_sequencer.sv
module tb_time_bin_sequencer;

  localparam int BC = 10;
  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, bin_ready;
  logic [31:0] pmt_count;
  logic        count_clear, bin_valid, busy, done, led;
  logic [7:0]  bin_data;
  logic [3:0]  bin_index;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic led_exp = 1'b0;

  time_bin_sequencer #(
    .BIN_CYCLES(BC),
    .NUM_BINS  (NB),
    .COUNT_W   (8),
    .IN_W      (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .pmt_count  (pmt_count),
    .count_clear(count_clear),
    .bin_data   (bin_data),
    .bin_index  (bin_index),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .busy       (busy),
    .done       (done),
    .led        (led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected count captured at a bin close: the value seen in the last cycle
  // of the window, clipped to 8 bits.
  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // mode 0: random counts, 1: ramp ending at 3,7,0,12, 2: random with 300 at bin 1 close
  // abort_t / start_t: cycle offset (after start) at which to assert abort / a stray start; -1 = never
  task automatic run_bins(input int mode, input int abort_t, input int start_t);
    int tgt[NB];
    int v, n, k;
    tgt = '{3, 7, 0, 12};
    exp_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clear", count_clear, 1);
    chk("start_busy", busy, 1);
    chk("start_valid", bin_valid, 0);
    for (int t = 1; t <= NB * BC; t++) begin
      n = (t - 1) / BC;
      k = (t - 1) % BC + 1;
      case (mode)
        1:       v = tgt[n] * k / BC;
        2:       v = (t == 2 * BC) ? 300 : int'($urandom_range(0, 400));
        default: v = int'($urandom_range(0, 400));
      endcase
      pmt_count = 32'(v);
      if (t == start_t) start = 1'b1;
      if (t == abort_t) abort = 1'b1;
      tick();
      start = 1'b0;
      if (t == abort_t) begin
        abort = 1'b0;
        chk("abort_clear", count_clear, 1);
        chk("abort_busy", busy, 0);
        chk("abort_valid", bin_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_led", led, led_exp);
        for (int j = 0; j < 3; j++) begin
          tick();
          chk("post_abort_clear", count_clear, 0);
          chk("post_abort_valid", bin_valid, 0);
          chk("post_abort_busy", busy, 0);
          chk("post_abort_done", done, 0);
        end
        return;
      end
      if (t % BC == 0) begin
        exp_q.push_back(sat8(v));
        led_exp = ~led_exp;
      end
      chk("run_clear", count_clear, (t % BC == 0) ? 1 : 0);
      chk("run_busy", busy, 1);
      chk("run_led", led, led_exp);
      chk("run_valid", bin_valid, (t == NB * BC) ? 1 : 0);
      chk("run_done", done, 0);
    end
  endtask

  // rmode 0: ready held high, 1: random ready. Stops after n_acc accepts.
  task automatic drain(input int rmode, input int n_acc);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    while (idx < n_acc && cyc < 200) begin
      chk("drain_valid", bin_valid, 1);
      chk("drain_index", bin_index, idx);
      chk("drain_data", bin_data, exp_q[idx]);
      chk("drain_busy", busy, 1);
      chk("drain_done", done, 0);
      rdy = (rmode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      bin_ready = rdy;
      tick();
      cyc++;
      if (rdy) idx++;
    end
    bin_ready = 1'b0;
    chk("drain_bound", (cyc < 200) ? 1 : 0, 1);
    if (n_acc == NB) begin
      chk("end_valid", bin_valid, 0);
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      tick();
      chk("end_done_clear", done, 0);
      chk("end_valid2", bin_valid, 0);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    bin_ready = 1'b0;
    pmt_count = '0;
    tick();
    tick();
    chk("rst_clear", count_clear, 0);
    chk("rst_valid", bin_valid, 0);
    chk("rst_data", bin_data, 0);
    chk("rst_index", bin_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_led", led, 0);
    reset_n = 1'b1;
    tick();

    // Directed ramp, consumer always ready
    run_bins(1, -1, -1);
    drain(0, NB);

    // Saturation of bin 1, throttled consumer
    run_bins(2, -1, -1);
    chk("sat_bin1", exp_q[1], 255);
    drain(1, NB);

    // Random run with random ready
    run_bins(0, -1, -1);
    drain(1, NB);

    // Abort at timer=5 of bin 2, then a clean run
    run_bins(0, 2 * BC + 6, -1);
    run_bins(0, -1, -1);
    drain(0, NB);

    // Stray start during RUN is ignored
    run_bins(0, -1, 13);
    drain(1, NB);

    // start+abort together in IDLE: stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("sa_busy", busy, 0);
      chk("sa_clear", count_clear, 0);
      chk("sa_valid", bin_valid, 0);
      tick();
    end

    // Abort during DRAIN
    run_bins(0, -1, -1);
    drain(0, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("dabort_clear", count_clear, 1);
    chk("dabort_valid", bin_valid, 0);
    chk("dabort_busy", busy, 0);
    chk("dabort_done", done, 0);
    tick();
    chk("dabort_clear2", count_clear, 0);

    // Reset mid-DRAIN
    run_bins(0, -1, -1);
    drain(1, 2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    led_exp = 1'b0;
    chk("mrst_clear", count_clear, 0);
    chk("mrst_valid", bin_valid, 0);
    chk("mrst_data", bin_data, 0);
    chk("mrst_index", bin_index, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_led", led, 0);
    tick();
    run_bins(0, -1, -1);
    chk("led_after_4", led, 0);
    drain(0, NB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
